multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS-subset datapath. Successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Adds LW, SW, BNE and J on top of R-type, ADDI and BEQ, and handshakes with a variable-latency memory via mem_req/mem_ack.
- Drives all datapath mux selects, write enables and ALU function, and keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit for the MIPS-subset datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// handshakes with a variable-latency memory and counts retired instructions.
module multicycle_ctrl #(
    parameter int OP_W  = 6,
    parameter int FN_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             rd_mux_s,
    output logic             wb_mux_s,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [FN_W-1:0]  alu_funct,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_WB_R   = 4'd4,
        S_WB_I   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    localparam logic [FN_W-1:0] FN_ADD  = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] FN_SUB  = FN_W'(6'b100010);

    state_t           state_reg;
    state_t           state_next;
    logic [OP_W-1:0]  op_reg;
    logic [CNT_W-1:0] retired_reg;
    logic             retire_next;

    // Next-state selection and retirement detection.
    always_comb begin
        state_next  = state_reg;
        retire_next = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (mem_ack) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Live opcode is used here; it is captured into op_reg this cycle.
                case (opcode)
                    OP_R:           state_next = S_EXEC_R;
                    OP_ADDI:        state_next = S_EXEC_I;
                    OP_LW, OP_SW:   state_next = S_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:           state_next = S_JUMP;
                    default:        state_next = S_FETCH;
                endcase
            end
            S_EXEC_R: state_next = S_WB_R;
            S_EXEC_I: state_next = S_WB_I;
            S_ADDR:   state_next = (op_reg == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ack) state_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    state_next  = S_FETCH;
                    retire_next = 1'b1;
                end
            end
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_next  = S_FETCH;
                retire_next = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // State, captured opcode and retired counter; reset wins over any late mem_ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) op_reg <= opcode;
            if (retire_next) retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    // Control outputs decoded from the current state, all held low during reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        rd_mux_s  = 1'b0;
        wb_mux_s  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_funct = FN_ADD;
        illegal   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ack;
                pc_write  = mem_ack;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_funct = funct;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                rd_mux_s  = 1'b1;
            end
            S_WB_I: reg_write = 1'b1;
            S_MEM_RD: mem_req = 1'b1;
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_mux_s  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_funct = FN_SUB;
                pc_src    = 2'd1;
                pc_write  = (op_reg == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            default: illegal = 1'b1;
        endcase
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            reg_write = 1'b0;
            rd_mux_s  = 1'b0;
            wb_mux_s  = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'd0;
            alu_funct = '0;
            illegal   = 1'b0;
        end
    end

    assign state   = rst_n ? state_reg : 4'd0;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instructions with random memory latency, checked against per-instruction
// expectations (cycle count, enable counts, selects) derived from the ISA rules.
module tb_multicycle_ctrl;

    localparam int OP_W  = 6;
    localparam int FN_W  = 6;
    localparam int CNT_W = 32;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [OP_W-1:0]  opcode;
    logic [FN_W-1:0]  funct;
    logic             zero;
    logic             mem_ack;
    logic             mem_req, mem_we, ir_write, pc_write, reg_write;
    logic             rd_mux_s, wb_mux_s, alu_src_a, illegal;
    logic [1:0]       pc_src, alu_src_b;
    logic [FN_W-1:0]  alu_funct;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.OP_W(OP_W), .FN_W(FN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .rd_mux_s(rd_mux_s), .wb_mux_s(wb_mux_s), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_funct(alu_funct), .illegal(illegal),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [CNT_W-1:0] model_retired = '0;

    // Per-instruction observations
    int         cyc, n_rw, n_req, n_we, n_pcw, n_ill, n_bad;
    logic       rw_rd, rw_wb;
    logic [1:0] br_src;
    logic [5:0] exec_fn;
    int         trace[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J};
    endfunction

    // Drive one instruction from FETCH back to FETCH; fw/dw are wait cycles
    // before mem_ack in the fetch and data accesses.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zv,
                             input int fw, input int dw);
        int fw_left;
        int dw_left;
        bit done;
        fw_left = fw;
        dw_left = dw;
        done = 0;
        cyc = 0; n_rw = 0; n_req = 0; n_we = 0; n_pcw = 0; n_ill = 0; n_bad = 0;
        rw_rd = 1'b0; rw_wb = 1'b0; br_src = 2'd0; exec_fn = 6'd0;
        trace.delete();
        opcode = op; funct = fn; zero = zv;
        while (!done) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (mem_req) begin
                if (state == 4'd0) begin
                    mem_ack = (fw_left == 0);
                    if (fw_left > 0) fw_left--;
                end else begin
                    mem_ack = (dw_left == 0);
                    if (dw_left > 0) dw_left--;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            trace.push_back(int'(state));
            if (reg_write) begin n_rw++; rw_rd = rd_mux_s; rw_wb = wb_mux_s; end
            if (mem_req) n_req++;
            if (mem_we) n_we++;
            if (mem_we && !mem_req) n_bad++;
            if (pc_write) n_pcw++;
            if (pc_write && !ir_write) br_src = pc_src;
            if (illegal) n_ill++;
            if (alu_src_a && alu_src_b == 2'd0) exec_fn = alu_funct;
            cyc++;
            @(posedge clk);
            #1;
            if (state == 4'd0 && trace[trace.size()-1] != 0) done = 1;
            else if (cyc >= 64) begin
                check("timeout", 64'(cyc), 64'(0));
                done = 1;
            end
        end
    endtask

    // Expectations from the instruction's class: CPI, enables and selects.
    task automatic verify(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic zv, input int fw, input int dw);
        int  cpi;
        bit  legal, is_mem, taken, writes;
        legal  = is_legal(op);
        is_mem = (op == OP_LW) || (op == OP_SW);
        taken  = (op == OP_J) || (op == OP_BEQ && zv) || (op == OP_BNE && !zv);
        writes = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW);
        case (op)
            OP_R, OP_ADDI, OP_SW:   cpi = 4;
            OP_LW:                  cpi = 5;
            OP_BEQ, OP_BNE, OP_J:   cpi = 3;
            default:                cpi = 2;
        endcase
        if (legal) model_retired = model_retired + 1;
        check({tag, ".cycles"},  64'(cyc),   64'(cpi + fw + (is_mem ? dw : 0)));
        check({tag, ".reg_wr"},  64'(n_rw),  64'(writes));
        check({tag, ".mem_req"}, 64'(n_req), 64'(fw + 1 + (is_mem ? dw + 1 : 0)));
        check({tag, ".mem_we"},  64'(n_we),  64'((op == OP_SW) ? dw + 1 : 0));
        check({tag, ".we_noreq"}, 64'(n_bad), 64'(0));
        check({tag, ".pc_wr"},   64'(n_pcw), 64'(1 + taken));
        check({tag, ".illegal"}, 64'(n_ill), 64'(!legal));
        check({tag, ".retired"}, 64'(retired), 64'(model_retired));
        if (writes) begin
            check({tag, ".rd_mux"}, 64'(rw_rd), 64'(op == OP_R));
            check({tag, ".wb_mux"}, 64'(rw_wb), 64'(op == OP_LW));
        end
        if (taken) check({tag, ".pc_src"}, 64'(br_src), 64'((op == OP_J) ? 2 : 1));
        if (op == OP_R) check({tag, ".alu_fn"}, 64'(exec_fn), 64'(fn));
        if (op == OP_BEQ || op == OP_BNE) check({tag, ".alu_fn"}, 64'(exec_fn), 64'(6'b100010));
        $display("instr %s op=%b fn=%b zero=%0b fw=%0d dw=%0d cycles=%0d retired=%0d",
                 tag, op, fn, zv, fw, dw, cyc, retired);
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic zv, input int fw, input int dw);
        run_instr(op, fn, zv, fw, dw);
        verify(tag, op, fn, zv, fw, dw);
    endtask

    logic [5:0] legal_ops [7];

    initial begin
        legal_ops = '{OP_R, OP_ADDI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J};

        // Reset held two cycles with inputs that would otherwise advance the FSM
        rst_n = 1'b0; mem_ack = 1'b1; opcode = OP_R; funct = 6'b100000; zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst.state", 64'(state), 64'(0));
        check("rst.retired", 64'(retired), 64'(0));
        check("rst.outputs", 64'({mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
                                  rd_mux_s, wb_mux_s, alu_src_a, alu_src_b, alu_funct, illegal}),
              64'(0));
        $display("reset state=%0d retired=%0d mem_req=%0b", state, retired, mem_req);
        mem_ack = 1'b0;
        rst_n = 1'b1;

        // ADD with immediate acks: states 0,1,2,4 then back to 0
        do_instr("add", OP_R, 6'b100000, 1'b0, 0, 0);
        check("add.trace_len", 64'(trace.size()), 64'(4));
        if (trace.size() == 4) begin
            check("add.trace1", 64'(trace[1]), 64'(1));
            check("add.trace2", 64'(trace[2]), 64'(2));
            check("add.trace3", 64'(trace[3]), 64'(4));
        end

        do_instr("lw_wait3", OP_LW, 6'd0, 1'b0, 0, 3);
        do_instr("beq_z1", OP_BEQ, 6'd0, 1'b1, 0, 0);
        do_instr("bne_z1", OP_BNE, 6'd0, 1'b1, 0, 0);
        do_instr("illegal", 6'b111111, 6'd0, 1'b0, 0, 0);
        do_instr("sw", OP_SW, 6'd0, 1'b0, 0, 0);
        do_instr("j", OP_J, 6'd0, 1'b0, 0, 0);
        do_instr("addi_fw2", OP_ADDI, 6'd0, 1'b0, 2, 0);

        // Randomized instruction stream with random memory latency
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 6)];
            end
            do_instr($sformatf("rnd%0d", i), op, 6'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while in MEM_RD with mem_ack arriving the same cycle
        opcode = OP_LW; zero = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); mem_ack = 1'b0; #1;
            if (state == 4'd7) break;
            mem_ack = 1'b1;
        end
        check("midrst.reached_mem_rd", 64'(state), 64'(7));
        rst_n = 1'b0; mem_ack = 1'b1;
        #1;
        check("midrst.req_low", 64'(mem_req), 64'(0));
        check("midrst.no_regwr", 64'(reg_write), 64'(0));
        @(posedge clk); #1;
        check("midrst.state", 64'(state), 64'(0));
        check("midrst.retired", 64'(retired), 64'(0));
        @(negedge clk);
        mem_ack = 1'b0; rst_n = 1'b1;
        #1;
        check("midrst.fetch_req", 64'(mem_req), 64'(1));
        check("midrst.no_regwr2", 64'(reg_write), 64'(0));
        $display("midreset state=%0d retired=%0d mem_req=%0b", state, retired, mem_req);
        model_retired = '0;
        do_instr("addi_after_rst", OP_ADDI, 6'd0, 1'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
